stopwatch_ctrl: RTL and testbench

Control sequencer for the MM:SS stopwatch datapath. It synchronises and debounces the pause button and the adjust/select switches, and holds the pause toggle. A 4-state mode FSM issues single-cycle increment strobes (run, adjust-minutes, adjust-seconds) and a digit blanking mask to the counter and display-scan logic. It sits between the board I/O and enable generator on one side and the digit counters and display mux on the other.

---
 rtl/stopwatch_ctrl.sv | 143 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: control sequencer for the MM:SS stopwatch.
// Synchronises and debounces the pause button and adjust/select switches,
// keeps the pause toggle, runs the mode FSM and issues single-cycle
// increment strobes plus a blinking digit blank mask.
module stopwatch_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_SAMPLES  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_1hz,
  input  logic       en_2hz,
  input  logic       en_10hz,
  input  logic       en_400hz,
  input  logic       pause_btn,
  input  logic       adjust_sw,
  input  logic       select_sw,
  output logic [1:0] mode,
  output logic       paused,
  output logic       count_tick,
  output logic       adj_min_tick,
  output logic       adj_sec_tick,
  output logic [3:0] blank_mask
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    PAUSED  = 2'b01,
    ADJ_MIN = 2'b10,
    ADJ_SEC = 2'b11
  } state_t;

  localparam logic [3:0] DB_LIMIT = 4'(DB_SAMPLES);

  state_t     state;
  state_t     state_next;
  logic [2:0] raw_in;
  logic [2:0] db_level;
  logic       pause_db;
  logic       adjust_db;
  logic       select_db;
  logic       pause_db_d;
  logic       blink_phase;
  logic       count_next;
  logic       adj_min_next;
  logic       adj_sec_next;

  // Bit 0 = pause, bit 1 = adjust, bit 2 = select; all share one conditioning path.
  assign raw_in    = {select_sw, adjust_sw, pause_btn};
  assign pause_db  = db_level[0];
  assign adjust_db = db_level[1];
  assign select_db = db_level[2];

  for (genvar g = 0; g < 3; g++) begin : g_cond
    logic [SYNC_STAGES-1:0] chain;
    logic [3:0]             cnt;
    logic                   level;
    logic                   sync_bit;

    assign sync_bit    = chain[SYNC_STAGES-1];
    assign db_level[g] = level;

    // Shift the raw asynchronous input through the synchroniser chain.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) chain <= '0;
      else       chain <= {chain[SYNC_STAGES-2:0], raw_in[g]};
    end

    // Accept a new level only after DB_SAMPLES consecutive disagreeing strobed samples.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt   <= '0;
        level <= 1'b0;
      end else if (en_400hz) begin
        if (sync_bit == level) begin
          cnt <= '0;
        end else if (cnt + 4'd1 == DB_LIMIT) begin
          level <= ~level;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

  // Toggle the pause flag on each debounced rising edge of the pause button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pause_db_d <= 1'b0;
      paused     <= 1'b0;
    end else begin
      pause_db_d <= pause_db;
      if (pause_db && !pause_db_d) paused <= ~paused;
    end
  end

  // Mode state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Next mode straight from the pause flag and debounced switches; pause wins.
  always_comb begin
    state_next = RUN;
    if (paused)                     state_next = PAUSED;
    else if (adjust_db && !select_db) state_next = ADJ_MIN;
    else if (adjust_db && select_db)  state_next = ADJ_SEC;
  end

  // Tick decisions and blank mask from the current (pre-update) mode.
  always_comb begin
    count_next   = en_1hz & (state == RUN);
    adj_min_next = en_2hz & (state == ADJ_MIN);
    adj_sec_next = en_2hz & (state == ADJ_SEC);
    blank_mask   = 4'b0000;
    if (blink_phase && state == ADJ_MIN) blank_mask = 4'b1100;
    if (blink_phase && state == ADJ_SEC) blank_mask = 4'b0011;
  end

  // Register the tick strobes and advance the blink phase while adjusting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_tick   <= 1'b0;
      adj_min_tick <= 1'b0;
      adj_sec_tick <= 1'b0;
      blink_phase  <= 1'b0;
    end else begin
      count_tick   <= count_next;
      adj_min_tick <= adj_min_next;
      adj_sec_tick <= adj_sec_next;
      if (state == ADJ_MIN || state == ADJ_SEC) begin
        if (en_10hz) blink_phase <= ~blink_phase;
      end else begin
        blink_phase <= 1'b0;
      end
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scenario tasks drive the controller; expected tick
// strobes are queued when their enable is driven and matched by a monitor.
module tb_stopwatch_ctrl;

  localparam logic [1:0] M_RUN = 2'b00, M_PAUSED = 2'b01, M_MIN = 2'b10, M_SEC = 2'b11;
  localparam logic [1:0] K_NONE = 2'd0, K_COUNT = 2'd1, K_MIN = 2'd2, K_SEC = 2'd3;

  typedef struct {
    logic [1:0] kind;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en_1hz = 1'b0, en_2hz = 1'b0, en_10hz = 1'b0, en_400hz = 1'b0;
  logic       pause_btn = 1'b0, adjust_sw = 1'b0, select_sw = 1'b0;
  logic [1:0] mode;
  logic       paused, count_tick, adj_min_tick, adj_sec_tick;
  logic [3:0] blank_mask;

  exp_t sb[$];
  exp_t mon_e;
  logic [1:0] mon_kind;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic exp_phase = 1'b0;

  stopwatch_ctrl #(.SYNC_STAGES(2), .DB_SAMPLES(4)) dut (
    .clk(clk), .reset(reset),
    .en_1hz(en_1hz), .en_2hz(en_2hz), .en_10hz(en_10hz), .en_400hz(en_400hz),
    .pause_btn(pause_btn), .adjust_sw(adjust_sw), .select_sw(select_sw),
    .mode(mode), .paused(paused),
    .count_tick(count_tick), .adj_min_tick(adj_min_tick), .adj_sec_tick(adj_sec_tick),
    .blank_mask(blank_mask)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp expected and observed ticks.
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every tick seen must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && (count_tick || adj_min_tick || adj_sec_tick)) begin
      mon_kind = count_tick ? K_COUNT : (adj_min_tick ? K_MIN : K_SEC);
      checks++;
      if ((32'(count_tick) + 32'(adj_min_tick) + 32'(adj_sec_tick)) > 1) begin
        errors++;
        $display("[TB] FAIL tick_onehot got %b%b%b required at most one", count_tick, adj_min_tick, adj_sec_tick);
      end else if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_unexpected got kind %0d at cycle %0d required no tick", mon_kind, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (mon_kind !== mon_e.kind || cyc !== mon_e.cyc) begin
          errors++;
          $display("[TB] FAIL sb_tick got kind %0d cycle %0d required kind %0d cycle %0d", mon_kind, cyc, mon_e.kind, mon_e.cyc);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input int n);
    repeat (n) begin
      en_400hz = 1'b1;
      step();
      en_400hz = 1'b0;
      step();
    end
  endtask

  task automatic pulse_1hz(input logic expect_tick);
    exp_t e;
    en_1hz = 1'b1;
    if (expect_tick) begin
      e.kind = K_COUNT;
      e.cyc  = cyc + 1;
      sb.push_back(e);
    end
    step();
    en_1hz = 1'b0;
    step();
  endtask

  task automatic pulse_2hz(input logic [1:0] kind);
    exp_t e;
    en_2hz = 1'b1;
    if (kind != K_NONE) begin
      e.kind = kind;
      e.cyc  = cyc + 1;
      sb.push_back(e);
    end
    step();
    en_2hz = 1'b0;
    step();
  endtask

  task automatic pulse_10hz();
    en_10hz = 1'b1;
    step();
    en_10hz = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (6) begin
      pause_btn = 1'($urandom); adjust_sw = 1'($urandom); select_sw = 1'($urandom);
      en_1hz = 1'($urandom); en_2hz = 1'($urandom); en_10hz = 1'($urandom); en_400hz = 1'($urandom);
      step();
    end
    checks++; if (mode !== M_RUN) begin errors++; $display("[TB] FAIL reset_mode got %b required %b", mode, M_RUN); end
    checks++; if (paused !== 1'b0) begin errors++; $display("[TB] FAIL reset_paused got %b required 0", paused); end
    checks++; if (blank_mask !== 4'b0000) begin errors++; $display("[TB] FAIL reset_mask got %b required 0000", blank_mask); end
    checks++; if ({count_tick, adj_min_tick, adj_sec_tick} !== 3'b000) begin errors++; $display("[TB] FAIL reset_ticks got %b required 000", {count_tick, adj_min_tick, adj_sec_tick}); end
    pause_btn = 1'b0; adjust_sw = 1'b0; select_sw = 1'b0;
    en_1hz = 1'b0; en_2hz = 1'b0; en_10hz = 1'b0; en_400hz = 1'b0;
    step();
    reset = 1'b0;
    step(3);
    repeat (3) begin
      pulse_1hz(1'b1);
      step(5);
    end
    checks++; if (sb.size() !== 0) begin errors++; $display("[TB] FAIL reset_run_pending got %0d required 0", sb.size()); end
  endtask

  task automatic test_debounce();
    pause_btn = 1'b1; step(4); strobe(3);
    pause_btn = 1'b0; step(4); strobe(2);
    checks++; if (paused !== 1'b0) begin errors++; $display("[TB] FAIL glitch_paused got %b required 0", paused); end
    checks++; if (mode !== M_RUN) begin errors++; $display("[TB] FAIL glitch_mode got %b required %b", mode, M_RUN); end
    pause_btn = 1'b1; step(4); strobe(3);
    en_400hz = 1'b1; step(); en_400hz = 1'b0;
    checks++; if (paused !== 1'b0) begin errors++; $display("[TB] FAIL press_lat0 got %b required 0", paused); end
    step();
    checks++; if (paused !== 1'b1) begin errors++; $display("[TB] FAIL press_lat1 got %b required 1", paused); end
    checks++; if (mode !== M_RUN) begin errors++; $display("[TB] FAIL press_mode_lat1 got %b required %b", mode, M_RUN); end
    step();
    checks++; if (mode !== M_PAUSED) begin errors++; $display("[TB] FAIL press_mode_lat2 got %b required %b", mode, M_PAUSED); end
    strobe(10);
    pulse_1hz(1'b0);
    pulse_2hz(K_NONE);
    checks++; if (paused !== 1'b1) begin errors++; $display("[TB] FAIL hold_paused got %b required 1", paused); end
    pause_btn = 1'b0; step(4); strobe(4);
    checks++; if (paused !== 1'b1) begin errors++; $display("[TB] FAIL release_paused got %b required 1", paused); end
    pause_btn = 1'b1; step(4); strobe(4); step(2);
    checks++; if (paused !== 1'b0) begin errors++; $display("[TB] FAIL repress_paused got %b required 0", paused); end
    checks++; if (mode !== M_RUN) begin errors++; $display("[TB] FAIL repress_mode got %b required %b", mode, M_RUN); end
    pause_btn = 1'b0; step(4); strobe(4);
    checks++; if (sb.size() !== 0) begin errors++; $display("[TB] FAIL debounce_pending got %0d required 0", sb.size()); end
  endtask

  task automatic test_adjust_min();
    adjust_sw = 1'b1; select_sw = 1'b0; step(4); strobe(4); step(2);
    checks++; if (mode !== M_MIN) begin errors++; $display("[TB] FAIL admin_mode got %b required %b", mode, M_MIN); end
    exp_phase = 1'b0;
    checks++; if (blank_mask !== 4'b0000) begin errors++; $display("[TB] FAIL admin_mask_start got %b required 0000", blank_mask); end
    for (int i = 0; i < 4; i++) begin
      pulse_2hz(K_MIN);
      pulse_1hz(1'b0);
      pulse_10hz();
      exp_phase = ~exp_phase;
      checks++;
      if (blank_mask !== (exp_phase ? 4'b1100 : 4'b0000)) begin
        errors++;
        $display("[TB] FAIL admin_blink%0d got %b required %b", i, blank_mask, (exp_phase ? 4'b1100 : 4'b0000));
      end
    end
    pulse_10hz();
    exp_phase = ~exp_phase;
    checks++; if (blank_mask !== 4'b1100) begin errors++; $display("[TB] FAIL admin_blink_hi got %b required 1100", blank_mask); end
    checks++; if (sb.size() !== 0) begin errors++; $display("[TB] FAIL admin_pending got %0d required 0", sb.size()); end
  endtask

  task automatic test_adjust_sec();
    select_sw = 1'b1; step(4); strobe(4); step(2);
    checks++; if (mode !== M_SEC) begin errors++; $display("[TB] FAIL adsec_mode got %b required %b", mode, M_SEC); end
    checks++; if (blank_mask !== 4'b0011) begin errors++; $display("[TB] FAIL adsec_mask_moved got %b required 0011", blank_mask); end
    pulse_2hz(K_SEC);
    pulse_1hz(1'b0);
    pause_btn = 1'b1; step(4); strobe(4); step(2);
    exp_phase = 1'b0;
    checks++; if (mode !== M_PAUSED) begin errors++; $display("[TB] FAIL prio_mode got %b required %b", mode, M_PAUSED); end
    checks++; if (blank_mask !== 4'b0000) begin errors++; $display("[TB] FAIL prio_mask got %b required 0000", blank_mask); end
    pulse_2hz(K_NONE);
    pulse_1hz(1'b0);
    pulse_10hz();
    checks++; if (blank_mask !== 4'b0000) begin errors++; $display("[TB] FAIL prio_mask_blink got %b required 0000", blank_mask); end
    pause_btn = 1'b0; step(4); strobe(4);
    pause_btn = 1'b1; step(4); strobe(4); step(2);
    checks++; if (mode !== M_SEC) begin errors++; $display("[TB] FAIL unpause_mode got %b required %b", mode, M_SEC); end
    pause_btn = 1'b0; step(4); strobe(4);
    adjust_sw = 1'b0; select_sw = 1'b0; step(4); strobe(4); step(2);
    checks++; if (mode !== M_RUN) begin errors++; $display("[TB] FAIL back_run_mode got %b required %b", mode, M_RUN); end
    checks++; if (sb.size() !== 0) begin errors++; $display("[TB] FAIL adsec_pending got %0d required 0", sb.size()); end
  endtask

  task automatic test_coincidence();
    exp_t e;
    adjust_sw = 1'b1; step(4); strobe(3);
    en_400hz = 1'b1; en_1hz = 1'b1;
    e.kind = K_COUNT; e.cyc = cyc + 1; sb.push_back(e);
    step();
    en_400hz = 1'b0; en_1hz = 1'b0;
    step();
    checks++; if (mode !== M_MIN) begin errors++; $display("[TB] FAIL coinc_mode got %b required %b", mode, M_MIN); end
    pulse_2hz(K_MIN);
    step(2);
    checks++; if (sb.size() !== 0) begin errors++; $display("[TB] FAIL coinc_pending got %0d required 0", sb.size()); end
  endtask

  task automatic test_mid_reset();
    select_sw = 1'b1; step(4); strobe(4); step(2);
    checks++; if (mode !== M_SEC) begin errors++; $display("[TB] FAIL mid_pre_mode got %b required %b", mode, M_SEC); end
    pulse_10hz();
    checks++; if (blank_mask !== 4'b0011) begin errors++; $display("[TB] FAIL mid_pre_mask got %b required 0011", blank_mask); end
    reset = 1'b1;
    select_sw = 1'b0;
    #1;
    checks++; if (mode !== M_RUN) begin errors++; $display("[TB] FAIL mid_rst_mode got %b required %b", mode, M_RUN); end
    checks++; if (blank_mask !== 4'b0000) begin errors++; $display("[TB] FAIL mid_rst_mask got %b required 0000", blank_mask); end
    checks++; if (paused !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_paused got %b required 0", paused); end
    checks++; if ({count_tick, adj_min_tick, adj_sec_tick} !== 3'b000) begin errors++; $display("[TB] FAIL mid_rst_ticks got %b required 000", {count_tick, adj_min_tick, adj_sec_tick}); end
    step(2);
    reset = 1'b0;
    step(6);
    checks++; if (mode !== M_RUN) begin errors++; $display("[TB] FAIL mid_post_mode got %b required %b", mode, M_RUN); end
    strobe(3); step(2);
    checks++; if (mode !== M_RUN) begin errors++; $display("[TB] FAIL mid_requal3 got %b required %b", mode, M_RUN); end
    strobe(1); step(2);
    checks++; if (mode !== M_MIN) begin errors++; $display("[TB] FAIL mid_requal4 got %b required %b", mode, M_MIN); end
    pulse_2hz(K_MIN);
    step(2);
    checks++; if (sb.size() !== 0) begin errors++; $display("[TB] FAIL mid_pending got %0d required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_adjust_min();
    test_adjust_sec();
    test_coincidence();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
